// File: rtl/alu_exec_ctrl.sv
// Execute-stage sequencer in front of alu_32bit: accepts an op, drives the ALU, returns result and flags.
// Define ALU_SLT_EN to enable SLT (second ALU pass through the less path); otherwise op 111 is unsupported.
module alu_exec_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic        alu_cin,
  output logic        alu_binv,
  output logic [31:0] alu_less,
  output logic        alu_sel1,
  output logic        alu_sel0,
  input  logic [31:0] alu_result,
  input  logic        alu_co,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_zero,
  output logic        out_ovf,
  output logic        out_err
);

  localparam int unsigned W = 32;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
`ifdef ALU_SLT_EN
  localparam logic [1:0] SLT2 = 2'd2;
`endif
  localparam logic [1:0] HOLD = 2'd3;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  // ALU control pins {sel1, sel0, binv, cin} for the first pass of an op
  function automatic logic [3:0] op_ctl(input logic [2:0] op);
    logic [3:0] c;
    case (op)
      OP_AND:  c = 4'b0000;
      OP_OR:   c = 4'b0100;
      OP_ADD:  c = 4'b1000;
      OP_SUB:  c = 4'b1011;
`ifdef ALU_SLT_EN
      OP_SLT:  c = 4'b1011;
`endif
      default: c = 4'b0000;
    endcase
    return c;
  endfunction

  function automatic logic op_supported(input logic [2:0] op);
    logic s;
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB: s = 1'b1;
`ifdef ALU_SLT_EN
      OP_SLT:  s = 1'b1;
`endif
      default: s = 1'b0;
    endcase
    return s;
  endfunction

  logic [1:0]   state_q, state_d;
  logic [2:0]   op_q, op_d;
  logic [W-1:0] alu_a_d, alu_b_d;
  logic         alu_cin_d, alu_binv_d, alu_sel1_d, alu_sel0_d;
  logic         out_valid_d, out_zero_d, out_ovf_d, out_err_d;
  logic [W-1:0] out_result_d;
  logic         ovf_add, ovf_sub, exec_ovf, is_slt;
  logic [W-1:0] exec_res;
  logic         unused_alu_co;

  assign unused_alu_co = alu_co;

  // Operand registers double as the ALU a/b pins, so flags can use them directly in EXEC
  assign ovf_add  = (alu_a[W-1] == alu_b[W-1]) & (alu_result[W-1] != alu_a[W-1]);
  assign ovf_sub  = (alu_a[W-1] != alu_b[W-1]) & (alu_result[W-1] != alu_a[W-1]);
  assign exec_res = op_supported(op_q) ? alu_result : '0;
  assign exec_ovf = (op_q == OP_ADD) ? ovf_add : ((op_q == OP_SUB) ? ovf_sub : 1'b0);
  assign in_ready = (state_q == IDLE) & ~rst;

`ifdef ALU_SLT_EN
  logic lt_q, lt_d;
  assign is_slt   = (op_q == OP_SLT);
  // lt is only held during SLT2, so it maps straight onto the less pin
  assign alu_less = {(W-1)'(0), lt_q};
`else
  assign is_slt   = 1'b0;
  assign alu_less = '0;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    alu_a_d      = alu_a;
    alu_b_d      = alu_b;
    alu_cin_d    = alu_cin;
    alu_binv_d   = alu_binv;
    alu_sel1_d   = alu_sel1;
    alu_sel0_d   = alu_sel0;
    out_valid_d  = out_valid;
    out_result_d = out_result;
    out_zero_d   = out_zero;
    out_ovf_d    = out_ovf;
    out_err_d    = out_err;
`ifdef ALU_SLT_EN
    lt_d         = lt_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = EXEC;
          op_d    = in_op;
          alu_a_d = in_a;
          alu_b_d = in_b;
          {alu_sel1_d, alu_sel0_d, alu_binv_d, alu_cin_d} = op_ctl(in_op);
        end
      end
      EXEC: begin
        if (is_slt) begin
`ifdef ALU_SLT_EN
          state_d = SLT2;
          lt_d    = alu_result[W-1] ^ ovf_sub;
          {alu_sel1_d, alu_sel0_d, alu_binv_d, alu_cin_d} = 4'b1111;
`endif
        end else begin
          state_d      = HOLD;
          out_valid_d  = 1'b1;
          out_result_d = exec_res;
          out_zero_d   = (exec_res == '0);
          out_ovf_d    = exec_ovf;
          out_err_d    = ~op_supported(op_q);
          alu_a_d      = '0;
          alu_b_d      = '0;
          {alu_sel1_d, alu_sel0_d, alu_binv_d, alu_cin_d} = 4'b0000;
        end
      end
`ifdef ALU_SLT_EN
      SLT2: begin
        state_d      = HOLD;
        out_valid_d  = 1'b1;
        out_result_d = alu_result;
        out_zero_d   = (alu_result == '0);
        out_ovf_d    = 1'b0;
        out_err_d    = 1'b0;
        alu_a_d      = '0;
        alu_b_d      = '0;
        lt_d         = 1'b0;
        {alu_sel1_d, alu_sel0_d, alu_binv_d, alu_cin_d} = 4'b0000;
      end
`endif
      HOLD: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_cin    <= 1'b0;
      alu_binv   <= 1'b0;
      alu_sel1   <= 1'b0;
      alu_sel0   <= 1'b0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_zero   <= 1'b0;
      out_ovf    <= 1'b0;
      out_err    <= 1'b0;
`ifdef ALU_SLT_EN
      lt_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      alu_a      <= alu_a_d;
      alu_b      <= alu_b_d;
      alu_cin    <= alu_cin_d;
      alu_binv   <= alu_binv_d;
      alu_sel1   <= alu_sel1_d;
      alu_sel0   <= alu_sel0_d;
      out_valid  <= out_valid_d;
      out_result <= out_result_d;
      out_zero   <= out_zero_d;
      out_ovf    <= out_ovf_d;
      out_err    <= out_err_d;
`ifdef ALU_SLT_EN
      lt_q       <= lt_d;
`endif
    end
  end

endmodule

// File: doc/alu_exec_ctrl.md
# alu_exec_ctrl

Execute-stage sequencer that sits directly upstream of `alu_32bit` in the MIPS datapath. It accepts a decoded ALU operation with its two operands over a valid/ready handshake and drives the combinational ALU's operand and control pins. It captures the ALU output, and for SLT runs a second pass through the ALU's `less` path. The final result, with zero, overflow and error flags, is held on an output valid/ready port for the MEM/writeback stage.

## Interface
- No parameters; datapath width fixed at 32.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  operation offered
- `in_ready`  out  1  block accepts operation this cycle
- `in_op`  in  3  ALU control code: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT; others unsupported
- `in_a`, `in_b`  in  32  operands
- `alu_a`, `alu_b`  out  32  to ALU `a`, `b`
- `alu_cin`, `alu_binv`  out  1  to ALU `cin`, `binv`
- `alu_less`  out  32  to ALU `less`
- `alu_sel1`, `alu_sel0`  out  1  ALU select: 00 AND, 01 OR, 10 ADD, 11 LESS
- `alu_result`  in  32  from ALU `result`
- `alu_co`  in  1  from ALU `co` (carry out, unused for flags)
- `out_valid`  out  1  result held
- `out_ready`  in  1  downstream accepts
- `out_result`  out  32  registered result
- `out_zero`, `out_ovf`, `out_err`  out  1  result==0, signed overflow, unsupported op

## Operation
- States: IDLE, EXEC, SLT2, HOLD.
- IDLE: `in_ready`=1 (forced 0 while `rst` is high). When `in_valid`, capture op, a and b into internal registers and go to EXEC.
- EXEC: drive the ALU from the captured registers.
  - AND: sel=00, binv=0, cin=0.
  - OR: sel=01, binv=0, cin=0.
  - ADD: sel=10, binv=0, cin=0.
  - SUB and SLT: sel=10, binv=1, cin=1.
  - Unsupported op: sel=00, binv=0, cin=0.
- EXEC, non-SLT op: at the clock edge, load `out_result`=`alu_result` (forced 0 for an unsupported op) and the flags, then go to HOLD.
- EXEC, SLT op: at the clock edge, latch `lt` = `alu_result[31]` ^ ovf_sub, then go to SLT2.
- SLT2: sel=11, binv=1, cin=1, `alu_less` = {31'b0, `lt`}. At the clock edge, capture `alu_result` and go to HOLD.
- `alu_less` = 0 in every state except SLT2.
- HOLD: `out_valid`=1 and all outputs stable. When `out_ready`, go to IDLE. `in_ready`=0 outside IDLE.
- Flag rules:
  - ADD: ovf = (a[31]==b[31]) & (r[31]!=a[31]).
  - SUB: ovf = (a[31]!=b[31]) & (r[31]!=a[31]).
  - AND, OR, SLT and unsupported ops: ovf=0.
  - zero = (out_result==0).
  - err=1 only for an unsupported op.
- IDLE: all `alu_*` outputs are 0.
- Reset (asynchronous, any state, including mid-SLT):
  - State returns to IDLE.
  - Operand registers, `out_result`, `out_zero`, `out_ovf`, `out_err` and `out_valid` clear to 0.
  - `alu_*` outputs are 0 and `lt` clears.
  - The in-flight operation is dropped and never appears on the output.

## Timing
- Acceptance edge E0: the cycle with `in_valid` & `in_ready`.
- Non-SLT op: `out_valid` rises after E0+1.
- SLT: `out_valid` rises after E0+2.
- `out_valid` falls on the edge where `out_ready` is high; `in_ready` returns 1 in the next cycle.
- Minimum issue interval: 3 cycles for non-SLT ops, 4 for SLT (with `out_ready` tied high).
- `out_ready` high on the first HOLD cycle is honoured in that cycle.
- `in_valid` outside IDLE is ignored; the upstream stage holds its data.
- `out_*` change only on state-register edges; none combinational from inputs.

## Configuration
- `ALU_SLT_EN` defined: SLT supported as above, with the SLT2 state.
- Not defined:
  - SLT2 state is removed and `alu_less` is tied to 0.
  - op 111 is treated as unsupported: result 0, err=1, non-SLT latency.

## Test plan
- Reset mid-SLT: assert `rst` while in SLT2 → `out_valid`=0, `out_result`=0, `in_ready`=1 in the first cycle after release; no stale output appears.
- ADD 0x7FFFFFFF + 0x00000001 → `out_result`=0x80000000, ovf=1, zero=0, `out_valid` after E0+1.
- SUB 0x00000005 − 0x00000005 → result 0, zero=1, ovf=0; ALU pins during EXEC: binv=1, cin=1, sel=10.
- SLT 0x80000000 vs 0x00000001 (signed, overflow case) → result 1. SLT 5 vs 3 → result 0. Both: `out_valid` after E0+2; `alu_less[0]` matches `lt` during SLT2.
- Backpressure: hold `out_ready`=0 for 5 cycles after an OR of 0xF0F00000 | 0x0000F0F0 → `out_result`=0xF0F0F0F0 stable, `in_ready`=0, new `in_valid` ignored.
- op 011 → result 0, err=1. With `ALU_SLT_EN` undefined, op 111 → err=1, latency E0+1.
